// File: rtl/usrt_pkg.sv
// Shared USRT constants and helpers: default synchroniser depth, default glitch
// filter length and the counter width function used by the edge detector.
package usrt_pkg;

    localparam int USRT_SYNC_STAGES_DEF = 2;
    localparam int USRT_FILTER_LEN_DEF  = 3;

    // Smallest width able to hold 0..n, never less than 1 bit.
    function automatic int usrt_cnt_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) <= n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/usrt_edge_chan.sv
// One USRT edge-detect channel: synchroniser, optional glitch filter and
// registered edge pulses. Filter is built only when USRT_EDGE_FILTER_EN is defined.
module usrt_edge_chan
    import usrt_pkg::*;
#(
    parameter int SYNC_STAGES = USRT_SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = USRT_FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic usrt_clk,
    input  logic en,
    output logic usrt_level,
    output logic usrt_pedge,
    output logic usrt_nedge
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("usrt_edge_chan: SYNC_STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filt
        $error("usrt_edge_chan: FILTER_LEN must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   accept;
    logic                   level_q, level_d;
    logic                   pedge_q, pedge_d;
    logic                   nedge_q, nedge_d;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], usrt_clk};
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef USRT_EDGE_FILTER_EN
    localparam int CW = usrt_cnt_w(FILTER_LEN);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter holds the number of consecutive samples that disagreed with the level.
    always_comb begin
        cnt_d  = '0;
        accept = 1'b0;
        if (s != level_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) accept = 1'b1;
            else                              cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign accept = (s != level_q);
`endif

    always_comb begin
        level_d = accept ? s : level_q;
        pedge_d = accept &  s & en;
        nedge_d = accept & ~s & en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            pedge_q <= 1'b0;
            nedge_q <= 1'b0;
        end else begin
            level_q <= level_d;
            pedge_q <= pedge_d;
            nedge_q <= nedge_d;
        end
    end

    assign usrt_level = level_q;
    assign usrt_pedge = pedge_q;
    assign usrt_nedge = nedge_q;

endmodule

// File: rtl/usrt_edge_detect.sv
// Multi-channel USRT clock/strobe edge detector: CHANNELS independent
// usrt_edge_chan instances. Glitch filter enabled by defining USRT_EDGE_FILTER_EN.
module usrt_edge_detect
    import usrt_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = USRT_SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = USRT_FILTER_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] usrt_clk,
    input  logic [CHANNELS-1:0] en,
    output logic [CHANNELS-1:0] usrt_level,
    output logic [CHANNELS-1:0] usrt_pedge,
    output logic [CHANNELS-1:0] usrt_nedge
);

    if (CHANNELS < 1) begin : g_bad_ch
        $error("usrt_edge_detect: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("usrt_edge_detect: SYNC_STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filt
        $error("usrt_edge_detect: FILTER_LEN must be >= 1");
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        usrt_edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .usrt_clk   (usrt_clk[ch]),
            .en         (en[ch]),
            .usrt_level (usrt_level[ch]),
            .usrt_pedge (usrt_pedge[ch]),
            .usrt_nedge (usrt_nedge[ch])
        );
    end

endmodule
